add16_reg: RTL and testbench
============================

Name: add16_reg

Overview:
- 16-bit ripple-carry adder/subtractor built from a 1-bit full-adder cell, with a registered result and status flags.
- It is the add path of the ALU: operands in, sum/difference plus flags out, one cycle later.
- The combinational core matches the classic add16/fullAdder pair. The wrapper adds a clock, a synchronous reset, a valid strobe and flags.

Parameters:
- WIDTH, 16, operand/result width. Only 16 is required to be verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands/op are valid this cycle
- sub  input  1  0 = in1+in2+cin; 1 = in1-in2 (in1 + ~in2 + 1, cin ignored)
- cin  input  1  carry-in for add
- in1  input  16  operand A, unsigned or two's complement
- in2  input  16  operand B
- out  output  16  registered result
- out_valid  output  1  out/flags valid, one cycle after in_valid
- carry  output  1  carry-out of bit 15 (for sub: 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  out == 0
- negative  output  1  out[15]

Behaviour:
- Reset (clk edge with rst=1): out=0, carry=0, overflow=0, zero=0, negative=0, out_valid=0. Reset dominates in_valid in the same cycle.
- Reset mid-operation: a pending result is discarded; out_valid is 0 on the cycle after reset.
- Core:
  - 16 chained full_adder cells. Bit i takes a=in1[i], b=in2[i]^sub, c=carry from bit i-1.
  - Carry into bit 0 = sub ? 1 : cin.
  - Full-adder equations: sum=a^b^c; carry=(a&b)|(c&(a^b)).
- Result is modulo 2^16: 0xFFFF+0x0001 gives out=0x0000, carry=1.
- overflow = carry into bit 15 XOR carry out of bit 15.
- zero and negative are derived from the new result in the same cycle it is registered.
- Latency 1: when in_valid=1 at edge N, out and flags update at edge N and out_valid=1 after edge N.
- in_valid=0 at an edge:
  - out_valid goes 0.
  - out and flags hold their previous values.
- Back-to-back in_valid: one result per cycle, no stalls, no backpressure.
- No X propagation: all registers are reset.

Decomposition:
- Shared package alu_pkg:
  - ALU_W=16
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1
  - flag index constants FLAG_C, FLAG_V, FLAG_Z, FLAG_N
- One sub-module, full_adder (a, b, c -> sum, carry), purely combinational.
- Instantiated 16 times via generate in add16_reg, followed by the output/flag register stage.

Test Plan:
- Basic add, in_valid=1, sub=0, cin=0, each pair held for one cycle:
  - 2+2 -> out=4
  - 10+5 -> out=15
  - 100+69 -> out=169
  - All with carry=0, overflow=0, zero=0, negative=0, out_valid=1 one cycle after each.
- full_adder truth table, all 8 (a,b,c) combinations:
  - 000->s0 c0; 001->s1 c0; 010->s1 c0; 011->s0 c1
  - 100->s1 c0; 101->s0 c1; 110->s0 c1; 111->s1 c1
- Wrap/flags:
  - 0xFFFF+0x0001 -> out=0x0000, carry=1, zero=1, overflow=0.
  - 0x7FFF+0x0001 -> out=0x8000, overflow=1, negative=1, carry=0.
  - cin=1, 0x0001+0x0001 -> 0x0003.
- Subtract:
  - 5-10 -> out=0xFFFB, carry=0, negative=1.
  - 10-10 -> out=0, zero=1, carry=1.
  - 0x8000-0x0001 -> 0x7FFF, overflow=1.
- Reset: apply operands 100+69 with in_valid=1 and rst=1 on the same edge -> out=0, out_valid=0. Release rst, re-drive -> out=169 one cycle later.
- Valid gating: in_valid pulses 1,0,1 with changing operands -> out_valid pattern 1,0,1. out holds the first result during the 0 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, op encodings and flag bit positions.
package alu_pkg;
    localparam int ALU_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_W = 4;
endpackage

// File: rtl/add16_reg_full_adder.sv
// One-bit full-adder cell; purely combinational, zero latency, no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/add16_reg.sv
// Ripple-carry add/sub with registered result and C/V/Z/N flags.
// Latency 1 cycle, accepts one operation per cycle, never stalls.
module add16_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [FLAG_W-1:0] flags;

    // Subtraction is in1 + ~in2 + 1, so the forced carry-in supplies the +1.
    assign c[0] = (sub == OP_SUB) ? 1'b1 : cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a     (in1[i]),
            .b     (in2[i] ^ sub),
            .c     (c[i]),
            .sum   (sum[i]),
            .carry (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out           <= sum;
                flags[FLAG_C] <= c[WIDTH];
                flags[FLAG_V] <= c[WIDTH] ^ c[WIDTH-1];
                flags[FLAG_Z] <= (sum == '0);
                flags[FLAG_N] <= sum[WIDTH-1];
            end
        end
    end

    assign carry    = flags[FLAG_C];
    assign overflow = flags[FLAG_V];
    assign zero     = flags[FLAG_Z];
    assign negative = flags[FLAG_N];
endmodule

// File: tb/tb_add16_reg.sv
// Directed bench for add16_reg with an arithmetic reference model and per-cycle compare.
module tb_add16_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic [15:0] out;
    logic        out_valid, carry, overflow, zero, negative;

    logic fa_a, fa_b, fa_c, fa_sum, fa_carry;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    logic [15:0] m_out;
    logic        m_valid;
    logic [3:0]  m_flags;  // {n, z, v, c}

    always #5 clk = ~clk;

    add16_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sub       (sub),
        .cin       (cin),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .out_valid (out_valid),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    full_adder u_fa (
        .a     (fa_a),
        .b     (fa_b),
        .c     (fa_c),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Reference: integer arithmetic, returns {n, z, v, c, result}.
    function automatic logic [19:0] model(input logic s, input logic ci,
                                          input logic [15:0] a, input logic [15:0] b);
        int ua, ub, tot, sa, sb, st;
        logic [15:0] r;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            tot = ua - ub;
            c   = (ua >= ub);
            st  = sa - sb;
        end else begin
            tot = ua + ub + int'(ci);
            c   = (tot > 65535);
            st  = sa + sb + int'(ci);
        end
        r = tot[15:0];
        v = (st > 32767) || (st < -32768);
        return {r[15], (r == 16'h0000), v, c, r};
    endfunction

    always @(posedge clk) begin
        logic [19:0] m;
        if (rst) begin
            m_out   = '0;
            m_flags = '0;
            m_valid = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m       = model(sub, cin, in1, in2);
                m_out   = m[15:0];
                m_flags = m[19:16];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (run_cmp) begin
                check("cyc_valid", 32'(out_valid), 32'(m_valid));
                check("cyc_out", 32'(out), 32'(m_out));
                check("cyc_flags", 32'({negative, zero, overflow, carry}), 32'(m_flags));
            end
        end
    end

    // Drive one operation at the falling edge, check literals just after the next rising edge.
    task automatic apply(input string name, input logic s, input logic ci,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e_out, input logic [3:0] e_nzvc);
        @(negedge clk);
        in_valid = 1'b1;
        sub = s;
        cin = ci;
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_out"}, 32'(out), 32'(e_out));
        check({name, "_flags"}, 32'({negative, zero, overflow, carry}), 32'(e_nzvc));
        check({name, "_model"}, 32'(model(s, ci, a, b)), 32'({e_nzvc, e_out}));
    endtask

    initial begin
        logic [7:0] fa_s_tab;
        logic [7:0] fa_c_tab;
        logic [2:0] idx;
        fa_s_tab = 8'b1001_0110;
        fa_c_tab = 8'b1110_1000;

        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {fa_a, fa_b, fa_c} = idx;
            #1;
            check($sformatf("fa_sum_%0d", i), 32'(fa_sum), 32'(fa_s_tab[idx]));
            check($sformatf("fa_carry_%0d", i), 32'(fa_carry), 32'(fa_c_tab[idx]));
        end

        repeat (2) @(posedge clk);
        #1;
        run_cmp = 1'b1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({negative, zero, overflow, carry}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply("add_2_2",     1'b0, 1'b0, 16'd2,     16'd2,     16'd4,     4'b0000);
        apply("add_10_5",    1'b0, 1'b0, 16'd10,    16'd5,     16'd15,    4'b0000);
        apply("add_100_69",  1'b0, 1'b0, 16'd100,   16'd69,    16'd169,   4'b0000);
        apply("wrap_ffff",   1'b0, 1'b0, 16'hFFFF,  16'h0001,  16'h0000,  4'b0101);
        apply("ovf_7fff",    1'b0, 1'b0, 16'h7FFF,  16'h0001,  16'h8000,  4'b1010);
        apply("cin_1_1",     1'b0, 1'b1, 16'h0001,  16'h0001,  16'h0003,  4'b0000);
        apply("sub_5_10",    1'b1, 1'b0, 16'd5,     16'd10,    16'hFFFB,  4'b1000);
        apply("sub_10_10",   1'b1, 1'b1, 16'd10,    16'd10,    16'h0000,  4'b0101);
        apply("sub_8000_1",  1'b1, 1'b0, 16'h8000,  16'h0001,  16'h7FFF,  4'b0011);

        // Reset wins over a valid operation on the same edge.
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        sub = 1'b0;
        cin = 1'b0;
        in1 = 16'd100;
        in2 = 16'd69;
        @(posedge clk);
        #1;
        check("rstv_out", 32'(out), 32'd0);
        check("rstv_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        apply("redrive_169", 1'b0, 1'b0, 16'd100, 16'd69, 16'd169, 4'b0000);

        apply("gate_1_2", 1'b0, 1'b0, 16'd1, 16'd2, 16'd3, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = 16'd7;
        in2 = 16'd7;
        @(posedge clk);
        #1;
        check("gate_idle_valid", 32'(out_valid), 32'd0);
        check("gate_idle_out", 32'(out), 32'd3);
        apply("gate_4_4", 1'b0, 1'b0, 16'd4, 16'd4, 16'd8, 4'b0000);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
